// File: rtl/interp_result_writer_if.sv
// Signal bundle between the bilinear interpolator, the result writer and the
// result-SRAM write port.
//
// Handshakes:
//   Pixel side: I_VALID/I_DATA come straight from the interpolator and have no
//   ready. A pixel is present for exactly one cycle, and only that cycle.
//   Write side: WEN is an active-low valid and W_READY is the ready. A write
//   transfers at a rising edge where WEN=0 and W_READY=1. While WEN=0 and
//   W_READY=0, W_ADDR and W_DATA hold their values. WEN returns to 1 without
//   a transfer only on START (head write abandoned) or RST.
interface interp_result_writer_if;
  logic       START;
  logic [7:0] I_DATA;
  logic       I_VALID;
  logic       WEN;
  logic [8:0] W_ADDR;
  logic [7:0] W_DATA;
  logic       W_READY;
  logic       BUSY;
  logic       DONE;
  logic       OVF;
  logic [7:0] MIN_PIX;
  logic [7:0] MAX_PIX;

  // Side that drives the pixel stream and grants SRAM writes.
  modport master (
    output START, I_DATA, I_VALID, W_READY,
    input  WEN, W_ADDR, W_DATA, BUSY, DONE, OVF, MIN_PIX, MAX_PIX
  );

  // The result writer itself.
  modport slave (
    input  START, I_DATA, I_VALID, W_READY,
    output WEN, W_ADDR, W_DATA, BUSY, DONE, OVF, MIN_PIX, MAX_PIX
  );
endinterface

// File: rtl/interp_result_writer.sv
// interp_result_writer: absorbs the interpolator's 289-pixel output stream
// (which cannot be stalled) into a small FIFO and drains it into the result
// SRAM through a back-pressured write port. Reports BUSY, a DONE pulse, a
// sticky overflow flag, and optional per-frame min/max.
//
// Build option: define STATS_EN to build the min/max statistics; without it
// MIN_PIX and MAX_PIX are tied to 0.
module interp_result_writer #(
  parameter int         DEPTH     = 8,
  parameter logic [8:0] BASE_ADDR = 9'd0
) (
  input  logic                  clk,
  input  logic                  RST,
  interp_result_writer_if.slave bus,
  output logic [1:0]            state_dbg
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [8:0]  LAST_IDX = 9'd288;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t      state;
  logic [16:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic [8:0]  in_idx;
  logic        busy_q;
  logic        done_q;
  logic        ovf_q;
  logic        empty;
  logic        full;
  logic        pop;
  logic        take;
  logic        push;
  logic        drop;
  logic        frame_end;
  logic [16:0] head;

  // FIFO status and per-cycle push/pop/drop decisions.
  always_comb begin
    count     = wr_ptr - rd_ptr;
    empty     = (count == '0);
    full      = (count == FULL_CNT);
    pop       = !empty && bus.W_READY;
    take      = bus.I_VALID && (state == COLLECT);
    // A full FIFO still accepts a pixel when the head leaves in the same cycle.
    push      = take && (!full || pop);
    drop      = take && full && !pop;
    frame_end = (state == FLUSH) && empty;
    head      = mem[rd_ptr[AW-1:0]];
  end

  // FIFO storage: each entry is {pixel index, pixel value}; no reset needed.
  always_ff @(posedge clk) begin
    if (push && !bus.START && !RST) begin
      mem[wr_ptr[AW-1:0]] <= {in_idx, bus.I_DATA};
    end
  end

  // Frame FSM, FIFO pointers, pixel counter and status flags.
  always_ff @(posedge clk) begin
    if (RST) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      in_idx <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.START) begin
      // START restarts from any state and discards whatever is queued.
      state  <= COLLECT;
      wr_ptr <= '0;
      rd_ptr <= '0;
      in_idx <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (drop) ovf_q  <= 1'b1;
      case (state)
        COLLECT: begin
          // Dropped pixels still advance the index so later pixels keep
          // their addresses and the drop leaves a hole.
          if (take) begin
            in_idx <= in_idx + 9'd1;
            if (in_idx == LAST_IDX) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (frame_end) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Write port is fed from FIFO storage and pointer registers only.
  // The address add wraps modulo 512 by width.
  assign bus.WEN    = empty;
  assign bus.W_ADDR = empty ? 9'd0 : (BASE_ADDR + head[16:8]);
  assign bus.W_DATA = empty ? 8'd0 : head[7:0];
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.OVF    = ovf_q;
  assign state_dbg  = state;

`ifdef STATS_EN
  logic [7:0] run_min;
  logic [7:0] run_max;
  logic [7:0] min_q;
  logic [7:0] max_q;

  // Running min/max over accepted pixels; published when the frame completes.
  always_ff @(posedge clk) begin
    if (RST) begin
      run_min <= 8'hFF;
      run_max <= 8'h00;
      min_q   <= 8'h00;
      max_q   <= 8'h00;
    end else if (bus.START) begin
      run_min <= 8'hFF;
      run_max <= 8'h00;
    end else begin
      if (push) begin
        if (bus.I_DATA < run_min) run_min <= bus.I_DATA;
        if (bus.I_DATA > run_max) run_max <= bus.I_DATA;
      end
      if (frame_end) begin
        min_q <= run_min;
        max_q <= run_max;
      end
    end
  end

  assign bus.MIN_PIX = min_q;
  assign bus.MAX_PIX = max_q;
`else
  assign bus.MIN_PIX = 8'h00;
  assign bus.MAX_PIX = 8'h00;
`endif

endmodule

// File: tb/tb_interp_result_writer.sv
// Bench for interp_result_writer: two instances (BASE_ADDR 0 and 300) share one
// stimulus stream; a queue-based frame model predicts every output each cycle.
`timescale 1ns/1ps
module tb_interp_result_writer;

  localparam int DEPTH  = 8;
  localparam int FRAME  = 289;
  localparam int BASE_B = 300;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [1:0] st_a;
  logic [1:0] st_b;

  always #5 clk = ~clk;

  interp_result_writer_if bus_a();
  interp_result_writer_if bus_b();

  interp_result_writer #(.DEPTH(DEPTH), .BASE_ADDR(9'd0)) dut_a (
    .clk(clk), .RST(rst), .bus(bus_a), .state_dbg(st_a)
  );
  interp_result_writer #(.DEPTH(DEPTH), .BASE_ADDR(9'd300)) dut_b (
    .clk(clk), .RST(rst), .bus(bus_b), .state_dbg(st_b)
  );

  assign bus_b.START   = bus_a.START;
  assign bus_b.I_DATA  = bus_a.I_DATA;
  assign bus_b.I_VALID = bus_a.I_VALID;
  assign bus_b.W_READY = bus_a.W_READY;

  // ---------------- reference model state ----------------
  logic [16:0] exp_q[$];      // pixels held for writing, {index, pixel}, head first
  bit  m_collect, m_drain, m_busy, m_done, m_ovf;
  int  m_seen, n_drop;
  int  m_lo, m_hi, m_min, m_max;
  bit  m_dropped[512];

  // scoreboard bookkeeping
  int  n_vec, n_bad;
  int  writes_a;
  bit  wr_a[512];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit          emp;
    logic [16:0] h;
    emp = (exp_q.size() == 0);
    check("wen_a", 32'(bus_a.WEN), 32'(emp));
    check("wen_b", 32'(bus_b.WEN), 32'(emp));
    if (!emp) begin
      h = exp_q[0];
      check("addr_a", 32'(bus_a.W_ADDR), 32'(h[16:8]));
      check("data_a", 32'(bus_a.W_DATA), 32'(h[7:0]));
      check("addr_b", 32'(bus_b.W_ADDR), 32'((BASE_B + int'(h[16:8])) % 512));
      check("data_b", 32'(bus_b.W_DATA), 32'(h[7:0]));
    end
    check("busy", 32'(bus_a.BUSY), 32'(m_busy));
    check("done", 32'(bus_a.DONE), 32'(m_done));
    check("done_b", 32'(bus_b.DONE), 32'(m_done));
    check("ovf", 32'(bus_a.OVF), 32'(m_ovf));
    check("min_pix", 32'(bus_a.MIN_PIX), 32'(m_min));
    check("max_pix", 32'(bus_a.MAX_PIX), 32'(m_max));
    if (bus_a.WEN === 1'b0 && bus_a.W_READY === 1'b1) begin
      writes_a++;
      wr_a[bus_a.W_ADDR] = 1'b1;
    end
  endtask

  // Frame behaviour at one rising edge, from the inputs present at that edge.
  task automatic model_edge();
    int pre;
    bit pop, take;
    m_done = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_collect = 0; m_drain = 0; m_busy = 0; m_ovf = 0; m_seen = 0;
      m_lo = 255; m_hi = 0; m_min = 0; m_max = 0;
      return;
    end
    if (bus_a.START) begin
      exp_q.delete();
      m_collect = 1; m_drain = 0; m_busy = 1; m_ovf = 0; m_seen = 0;
      m_lo = 255; m_hi = 0; n_drop = 0;
      for (int i = 0; i < 512; i++) m_dropped[i] = 1'b0;
      return;
    end
    pre  = exp_q.size();
    pop  = (pre > 0) && (bus_a.W_READY === 1'b1);
    take = m_collect && (bus_a.I_VALID === 1'b1);
    if (pop) void'(exp_q.pop_front());
    if (take) begin
      if (pre < DEPTH || pop) begin
        exp_q.push_back({9'(m_seen), bus_a.I_DATA});
        if (int'(bus_a.I_DATA) < m_lo) m_lo = int'(bus_a.I_DATA);
        if (int'(bus_a.I_DATA) > m_hi) m_hi = int'(bus_a.I_DATA);
      end else begin
        m_ovf = 1'b1;
        m_dropped[m_seen] = 1'b1;
        n_drop++;
      end
      m_seen++;
      if (m_seen == FRAME) begin
        m_collect = 0;
        m_drain   = 1;
      end
    end else if (m_drain && pre == 0) begin
      m_drain = 0;
      m_busy  = 0;
      m_done  = 1;
`ifdef STATS_EN
      m_min = m_lo;
      m_max = m_hi;
`endif
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input bit s, input bit v, input logic [7:0] d, input bit r);
    bus_a.START   = s;
    bus_a.I_VALID = v;
    bus_a.I_DATA  = d;
    bus_a.W_READY = r;
  endtask

  // One cycle: check outputs mid-cycle, advance the model at the edge,
  // then return just after the edge so the caller can drive new inputs.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // dmode: 0 = index mod 256, 1 = random 0..255, 2 = random 17..240 with both
  // extremes present. stop_after > 0 abandons the frame after that many pixels.
  task automatic run_frame(input int valid_pct, input int ready_pct, input int stall_at,
                           input int stall_len, input int dmode, input int stop_after);
    int         c, sent, guard;
    logic [7:0] d;
    bit         rdy;
    set_in(1'b1, 1'b0, 8'd0, 1'b0);
    tick();
    writes_a = 0;
    for (int i = 0; i < 512; i++) wr_a[i] = 1'b0;
    c = 0;
    sent = 0;
    while (sent < FRAME && (stop_after == 0 || sent < stop_after)) begin
      if (c >= stall_at && c < stall_at + stall_len) rdy = 1'b0;
      else rdy = ($urandom_range(0, 99) < ready_pct);
      if ($urandom_range(0, 99) < valid_pct) begin
        case (dmode)
          0:       d = sent[7:0];
          1:       d = 8'($urandom_range(0, 255));
          default: d = (sent == 5) ? 8'd17 : (sent == 100) ? 8'd240 : 8'($urandom_range(17, 240));
        endcase
        set_in(1'b0, 1'b1, d, rdy);
        sent++;
      end else begin
        set_in(1'b0, 1'b0, 8'($urandom_range(0, 255)), rdy);
      end
      tick();
      c++;
    end
    if (stop_after != 0) return;
    guard = 0;
    while (!m_done && guard < 3000) begin
      set_in(1'b0, 1'b0, 8'd0, ($urandom_range(0, 99) < ready_pct));
      tick();
      guard++;
    end
    if (!m_done) check("done_timeout", 32'(bus_a.DONE), 32'd1);
    // observe the DONE cycle and the one after it
    set_in(1'b0, 1'b0, 8'd0, 1'b1);
    tick();
    tick();
    check("frame_writes", 32'(writes_a), 32'(FRAME - n_drop));
    for (int i = 0; i < FRAME; i++) check("addr_written", 32'(wr_a[i]), 32'(!m_dropped[i]));
    // stray pixels while idle must be ignored
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      tick();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int exp_min, exp_max;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    set_in(1'b0, 1'b0, 8'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_wen", 32'(bus_a.WEN), 32'd1);
    check("rst_waddr", 32'(bus_a.W_ADDR), 32'd0);
    check("rst_wdata", 32'(bus_a.W_DATA), 32'd0);
    check("rst_busy", 32'(bus_a.BUSY), 32'd0);
    check("rst_done", 32'(bus_a.DONE), 32'd0);
    check("rst_ovf", 32'(bus_a.OVF), 32'd0);
    check("rst_min", 32'(bus_a.MIN_PIX), 32'd0);
    check("rst_max", 32'(bus_a.MAX_PIX), 32'd0);
    @(posedge clk);
    model_edge();
    #1;

    // full-rate frame, data = index mod 256
    run_frame(100, 100, 0, 0, 0, 0);
    check("full_writes", 32'(writes_a), 32'd289);
    check("full_ovf", 32'(bus_a.OVF), 32'd0);

    // one entry is in flight at full rate, so 7 stalled edges just fill DEPTH
    run_frame(100, 100, 100, 7, 1, 0);
    check("bp_writes", 32'(writes_a), 32'd289);
    check("bp_ovf", 32'(bus_a.OVF), 32'd0);

    // 11 stalled edges: 7 fill the FIFO, the remaining 4 pixels are dropped
    run_frame(100, 100, 100, 11, 1, 0);
    check("ovf_writes", 32'(writes_a), 32'd285);
    check("ovf_flag", 32'(bus_a.OVF), 32'd1);

    // three pixels queued with the port stalled, then a fresh START
    run_frame(100, 0, 0, 0, 1, 3);
    run_frame(100, 100, 0, 0, 1, 0);
    check("restart_writes", 32'(writes_a), 32'd289);

    // RST in the middle of a frame
    run_frame(100, 50, 0, 0, 1, 40);
    rst = 1'b1;
    set_in(1'b0, 1'b0, 8'd0, 1'b1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_wen", 32'(bus_a.WEN), 32'd1);
    check("midrst_busy", 32'(bus_a.BUSY), 32'd0);
    check("midrst_ovf", 32'(bus_a.OVF), 32'd0);
    @(posedge clk);
    model_edge();
    #1;

    // statistics frame with pixels in 17..240
`ifdef STATS_EN
    exp_min = 17;
    exp_max = 240;
`else
    exp_min = 0;
    exp_max = 0;
`endif
    run_frame(100, 100, 0, 0, 2, 0);
    check("stats_min", 32'(bus_a.MIN_PIX), 32'(exp_min));
    check("stats_max", 32'(bus_a.MAX_PIX), 32'(exp_max));

    // randomized frames, including heavy back-pressure
    for (int f = 0; f < 5; f++) begin
      run_frame(50 + $urandom_range(0, 50), 20 + $urandom_range(0, 80), 0, 0, 1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
